// File: rtl/playback_replay_ffu_if.sv
// Bundle between the FFU replay engine and its environment: record loading,
// replay control, the drive/observe pair for the FFU under test, and status.
interface playback_replay_ffu_if #(
    parameter int IN_W  = 269,
    parameter int OUT_W = 198,
    parameter int AW    = 10
);
    logic                  load_vld;
    logic [AW-1:0]         load_addr;
    logic [IN_W+OUT_W:0]   load_data;
    logic                  start;
    logic [AW:0]           num_vec;
    logic                  pause;
    logic                  stop_on_fail;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           err_cnt;
    logic                  first_err_vld;
    logic [AW-1:0]         first_err_idx;
    logic [AW:0]           cur_idx;

    modport master (
        output load_vld, load_addr, load_data, start, num_vec, pause, stop_on_fail, dut_out,
        input  dut_in, busy, done, pass, err_cnt, first_err_vld, first_err_idx, cur_idx
    );

    modport slave (
        input  load_vld, load_addr, load_data, start, num_vec, pause, stop_on_fail, dut_out,
        output dut_in, busy, done, pass, err_cnt, first_err_vld, first_err_idx, cur_idx
    );
endinterface

// File: rtl/playback_replay_ffu.sv
// Replays recorded {clk_flag, in_vec, exp_vec} records into a standalone FFU,
// one per rclk, and compares the FFU outputs against the recorded values.
module playback_replay_ffu #(
    parameter int IN_W  = 269,
    parameter int OUT_W = 198,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 rclk,
    input  logic                 arst,
    playback_replay_ffu_if.slave bus
);
    localparam int          REC_W   = 1 + IN_W + OUT_W;
    localparam logic [AW:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_t;

    state_t            state;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [REC_W-1:0]  rd_data;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_sel;
    logic              rd_en;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  cur_exp;
    logic              cur_flag;
    logic [AW:0]       num_lat;
    logic              stop_lat;
    logic              busy, done, pass, first_err_vld;
    logic [15:0]       err_cnt;
    logic [15:0]       err_cnt_next;
    logic [AW-1:0]     first_err_idx;
    logic [AW:0]       cur_idx;
    logic              idle_like, launch, advance, mismatch, last;

    assign idle_like    = (state == IDLE) || (state == DONE);
    assign launch       = idle_like && bus.start && (bus.num_vec != '0);
    assign advance      = (state == RUN) && !bus.pause;
    assign mismatch     = advance && cur_flag && (bus.dut_out != cur_exp);
    assign err_cnt_next = (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    assign last         = advance && ((cur_idx + IDX_ONE == num_lat) || (mismatch && stop_lat));

    // rd_data doubles as the one-record lookahead; it only moves when a read is issued.
    assign rd_en  = launch || (state == PREFETCH) || advance;
    assign rd_sel = launch ? '0 : rd_ptr;

    // NOTE: the vector RAM and its read register carry no reset so they map onto block RAM;
    // loaded records also survive an arst this way.
    always_ff @(posedge rclk) begin
        if (bus.load_vld && idle_like)
            mem[bus.load_addr] <= bus.load_data;
        if (rd_en)
            rd_data <= mem[rd_sel];
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            state         <= IDLE;
            dut_in        <= '0;
            cur_exp       <= '0;
            cur_flag      <= 1'b0;
            num_lat       <= '0;
            stop_lat      <= 1'b0;
            rd_ptr        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            cur_idx       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        err_cnt       <= '0;
                        first_err_vld <= 1'b0;
                        if (bus.num_vec == '0) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            pass          <= 1'b1;
                            first_err_idx <= '0;
                            cur_idx       <= '0;
                        end else begin
                            state    <= PREFETCH;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            num_lat  <= bus.num_vec;
                            stop_lat <= bus.stop_on_fail;
                            rd_ptr   <= AW'(1);
                        end
                    end
                end
                PREFETCH: begin
                    state    <= RUN;
                    dut_in   <= rd_data[OUT_W +: IN_W];
                    cur_exp  <= rd_data[OUT_W-1:0];
                    cur_flag <= rd_data[REC_W-1];
                    cur_idx  <= '0;
                    rd_ptr   <= rd_ptr + AW'(1);
                end
                RUN: begin
                    if (!bus.pause) begin
                        err_cnt <= err_cnt_next;
                        cur_idx <= cur_idx + IDX_ONE;
                        if (mismatch && !first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= cur_idx[AW-1:0];
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt_next == '0);
                        end else begin
                            dut_in   <= rd_data[OUT_W +: IN_W];
                            cur_exp  <= rd_data[OUT_W-1:0];
                            cur_flag <= rd_data[REC_W-1];
                            rd_ptr   <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in        = dut_in;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.err_cnt       = err_cnt;
    assign bus.first_err_vld = first_err_vld;
    assign bus.first_err_idx = first_err_idx;
    assign bus.cur_idx       = cur_idx;
endmodule

// File: tb/tb_playback_replay_ffu.sv
// Bench for playback_replay_ffu: a looped-back FFU model, a table of replay
// cases with a per-cycle dut_in scoreboard, and hand-written reset sequences.
`timescale 1ns/1ps
module tb_playback_replay_ffu;
    localparam int IN_W  = 269;
    localparam int OUT_W = 198;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct {
        string       name;
        int          n;
        bit          stop;
        logic [15:0] bad;
        logic [15:0] noflag;
        int          pause_at;
        int          pause_len;
        bit          poke;
        int          e_err;
        bit          e_fvld;
        int          e_fidx;
        bit          e_pass;
        int          e_cur;
        int          e_busy;
    } case_t;

    typedef struct {
        int              idx;
        logic [IN_W-1:0] vec;
    } sb_t;

    logic rclk = 1'b0;
    logic arst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    case_t            cases[7];
    sb_t              sb[$];
    logic [IN_W-1:0]  rec_in  [16];
    logic [OUT_W-1:0] rec_exp [16];
    logic             rec_flag[16];

    playback_replay_ffu_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();

    playback_replay_ffu #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .rclk (rclk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    // The FFU under test: a pure combinational fold of its input vector.
    function automatic logic [OUT_W-1:0] ffu(input logic [IN_W-1:0] x);
        return x[OUT_W-1:0] ^ x[IN_W-1:IN_W-OUT_W];
    endfunction

    assign bus.dut_out = ffu(bus.dut_in);

    function automatic logic [IN_W-1:0] rand_in();
        logic [IN_W-1:0] v;
        v = '0;
        for (int i = 0; i < (IN_W + 31) / 32; i++)
            v = {v[IN_W-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit e_busy, input bit e_done, input bit e_pass,
                                 input int e_err, input bit e_fvld, input int e_cur);
        check({tag, "/busy"},          IN_W'(bus.busy),          IN_W'(e_busy));
        check({tag, "/done"},          IN_W'(bus.done),          IN_W'(e_done));
        check({tag, "/pass"},          IN_W'(bus.pass),          IN_W'(e_pass));
        check({tag, "/err_cnt"},       IN_W'(bus.err_cnt),       IN_W'(e_err));
        check({tag, "/first_err_vld"}, IN_W'(bus.first_err_vld), IN_W'(e_fvld));
        check({tag, "/cur_idx"},       IN_W'(bus.cur_idx),       IN_W'(e_cur));
    endtask

    task automatic load_records(input case_t c);
        for (int k = 0; k < c.n; k++) begin
            rec_in[k]   = rand_in();
            rec_flag[k] = !c.noflag[k];
            rec_exp[k]  = ffu(rec_in[k]) ^ OUT_W'(c.bad[k]);
            bus.load_vld  = 1'b1;
            bus.load_addr = AW'(k);
            bus.load_data = {rec_flag[k], rec_in[k], rec_exp[k]};
            @(negedge rclk);
        end
        bus.load_vld = 1'b0;
    endtask

    task automatic run_case(input case_t c, input bit reload);
        int  m_idx    = 0;
        int  paused   = 0;
        int  busy_cnt = 0;
        bit  finished = 1'b0;
        bit  mis;
        sb_t e;
        sb.delete();
        if (reload) load_records(c);
        bus.start        = 1'b1;
        bus.num_vec      = (AW+1)'(c.n);
        bus.stop_on_fail = c.stop;
        sb.push_back('{0, rec_in[0]});
        @(negedge rclk);
        bus.start        = 1'b0;
        bus.stop_on_fail = !c.stop;
        if (bus.busy) busy_cnt++;
        check({c.name, "/busy_after_start"}, IN_W'(bus.busy), IN_W'(1));
        check({c.name, "/done_cleared"},     IN_W'(bus.done), IN_W'(0));
        @(negedge rclk);
        for (int cyc = 0; cyc < 256 && !finished; cyc++) begin
            if (bus.busy) busy_cnt++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({c.name, "/sb_cur_idx"}, IN_W'(bus.cur_idx), IN_W'(e.idx));
                check({c.name, "/sb_dut_in"},  bus.dut_in,         e.vec);
            end
            bus.pause = (m_idx == c.pause_at) && (paused < c.pause_len);
            if (c.poke && cyc == 2) begin
                bus.load_vld  = 1'b1;
                bus.load_addr = AW'(c.n - 1);
                bus.load_data = {1'b1, rec_in[c.n-1], ~rec_exp[c.n-1]};
                bus.start     = 1'b1;
                bus.num_vec   = (AW+1)'(1);
            end
            if (bus.pause) begin
                paused++;
                sb.push_back('{m_idx, rec_in[m_idx]});
            end else begin
                mis = rec_flag[m_idx] && (ffu(rec_in[m_idx]) != rec_exp[m_idx]);
                m_idx++;
                if (m_idx == c.n || (c.stop && mis)) finished = 1'b1;
                else sb.push_back('{m_idx, rec_in[m_idx]});
            end
            @(negedge rclk);
            bus.pause    = 1'b0;
            bus.load_vld = 1'b0;
            bus.start    = 1'b0;
        end
        check({c.name, "/finished"}, IN_W'(finished), IN_W'(1));
        check_outputs(c.name, 1'b0, 1'b1, c.e_pass, c.e_err, c.e_fvld, c.e_cur);
        if (c.e_fvld)
            check({c.name, "/first_err_idx"}, IN_W'(bus.first_err_idx), IN_W'(c.e_fidx));
        check({c.name, "/busy_cycles"}, IN_W'(busy_cnt), IN_W'(c.e_busy));
        check({c.name, "/dut_in_hold"}, bus.dut_in, rec_in[m_idx-1]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;
        //            name         n  stop bad      noflag   pa  pl poke err fv fi pass cur busy
        cases[0] = '{"clean",     4, 0, 16'h0000, 16'h0000, -1, 0, 0,  0, 0, 0, 1, 4, 5};
        cases[1] = '{"bad2",      4, 0, 16'h0004, 16'h0000, -1, 0, 0,  1, 1, 2, 0, 4, 5};
        cases[2] = '{"noflag0",   4, 0, 16'h0001, 16'h0001, -1, 0, 0,  0, 0, 0, 1, 4, 5};
        cases[3] = '{"stop13",    4, 1, 16'h000A, 16'h0000, -1, 0, 0,  1, 1, 1, 0, 2, 3};
        cases[4] = '{"pause1",    4, 0, 16'h0000, 16'h0000,  1, 3, 1,  0, 0, 0, 1, 4, 8};
        cases[5] = '{"multi",     6, 0, 16'h001A, 16'h0000, -1, 0, 0,  3, 1, 1, 0, 6, 7};
        cases[6] = '{"pause_mis", 4, 0, 16'h0004, 16'h0000,  2, 2, 0,  1, 1, 2, 0, 4, 7};

        bus.load_vld = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 1'b0; bus.num_vec = '0; bus.pause = 1'b0; bus.stop_on_fail = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        check("reset/dut_in", bus.dut_in, '0);
        check("reset/first_err_idx", IN_W'(bus.first_err_idx), IN_W'(0));
        repeat (2) @(negedge rclk);
        arst = 1'b0;
        @(negedge rclk);

        for (int i = 0; i < 7; i++) run_case(cases[i], 1'b1);

        // Zero-length replay from a failing DONE: counters clear, pass on the next edge.
        bus.start   = 1'b1;
        bus.num_vec = '0;
        @(negedge rclk);
        bus.start = 1'b0;
        check_outputs("num_vec0", 1'b0, 1'b1, 1'b1, 0, 1'b0, 0);

        // Async reset in the middle of a replay, then replay again from the retained RAM.
        load_records(cases[0]);
        bus.start   = 1'b1;
        bus.num_vec = (AW+1)'(4);
        @(negedge rclk);
        bus.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge rclk);
            hit = bus.busy && (bus.cur_idx == (AW+1)'(2));
        end
        check("arst/reached_idx2", IN_W'(hit), IN_W'(1));
        #3 arst = 1'b1;
        #1;
        check_outputs("arst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        check("arst/dut_in", bus.dut_in, '0);
        @(negedge rclk);
        check("arst/held_busy", IN_W'(bus.busy), IN_W'(0));
        arst = 1'b0;
        @(negedge rclk);
        run_case(cases[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/playback_replay_ffu.md
Name: playback_replay_ffu

Overview:
- Replays recorded FFU vector records into a standalone FFU and checks its responses. This is the reader side of the FFU stimulus dump.
- Each record holds {clk_flag, input_vector[268:0], expected_output[197:0]}. Records are loaded into an internal vector RAM, driven onto the FFU inputs one per rclk, and the FFU outputs are compared against the expected values.
- Sits in the manycore verification environment, used on FPGA and emulation FFU-only builds.

Parameters:
IN_W, 269, width of the FFU input vector
OUT_W, 198, width of the FFU output vector
DEPTH, 1024, number of records in the vector RAM
AW, 10, record address width (log2 DEPTH)

Ports:
rclk  input  1  core clock, same clock as the FFU under test
arst  input  1  asynchronous reset, active-high
load_vld  input  1  write a record into the vector RAM
load_addr  input  AW  record address
load_data  input  1+IN_W+OUT_W  {clk_flag, in_vec, exp_vec}
start  input  1  pulse; begin replay of records 0..num_vec-1
num_vec  input  AW+1  record count, sampled on start
pause  input  1  hold replay in place
stop_on_fail  input  1  end replay at first mismatch, sampled on start
dut_in  output  IN_W  registered drive to the FFU inputs
dut_out  input  OUT_W  FFU outputs
busy  output  1  replay in progress
done  output  1  replay finished; sticky until next start
pass  output  1  valid when done; 1 if err_cnt==0
err_cnt  output  16  mismatch count, saturates at 16'hFFFF
first_err_vld  output  1  a mismatch has been captured
first_err_idx  output  AW  index of the first mismatching record
cur_idx  output  AW+1  record currently applied on dut_in

Behaviour:
- Reset values (arst asserted, asynchronous): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vld=0, first_err_idx=0, cur_idx=0. Vector RAM contents are not reset.
- Vector RAM: synchronous write, registered read with 1-cycle latency.
  - load_vld is honoured only in IDLE and DONE; it is ignored while busy.
- FSM states: IDLE, PREFETCH, RUN, DONE.
- IDLE/DONE + start:
  - num_vec==0: go to DONE with pass=1; counters are cleared.
  - otherwise: clear err_cnt, first_err_vld, done and pass; latch num_vec and stop_on_fail; set busy=1; read record 0; go to PREFETCH.
- PREFETCH (1 cycle): dut_in<=in_0, cur_idx<=0, issue read of record 1; go to RUN.
- RUN cycle k (pause=0):
  - dut_in holds in_k for the whole cycle.
  - At the closing edge, if flag_k=1 and dut_out!=exp_k: err_cnt increments (saturating). If first_err_vld=0, capture first_err_idx<=k and set first_err_vld.
  - flag_k=0 records are pre-clock settling vectors: applied for one cycle, never compared.
  - At the same edge: dut_in<=in_{k+1}, cur_idx<=k+1, and the read of record k+2 is issued. A prefetch register guarantees one record of lookahead.
- RUN with pause=1: dut_in, cur_idx and the prefetch are held; no compare is made that cycle.
- RUN exit: after the compare of record num_vec-1, or on a mismatch when stop_on_fail=1 (that mismatch is counted). Then:
  - go to DONE with busy=0, done=1, pass=(err_cnt_next==0);
  - dut_in holds its last value.
- start while busy is ignored. start in DONE restarts the replay.
- Latency: start to first compare is 2 edges; total replay is num_vec+1 cycles plus paused cycles.
- Simultaneous pause and mismatch: no compare is made while paused, so the mismatch is not counted.
- Asserting arst mid-replay returns to the reset state immediately. Loaded records remain valid for a subsequent start.

Test Plan:
- Load 4 records, flag=1, exp equal to a looped-back dut_out model; start, num_vec=4 -> busy for 5 cycles, done=1, pass=1, err_cnt=0.
- Same setup, but record 2 exp has bit 0 flipped -> err_cnt=1, first_err_vld=1, first_err_idx=2, pass=0.
- Record 0 has flag=0 and a mismatching exp -> no count; err_cnt=0, pass=1.
- Records 1 and 3 mismatch, stop_on_fail=1 -> DONE reached after the record 1 compare, err_cnt=1, cur_idx=2.
- Hold pause for 3 cycles at cur_idx=1 -> dut_in stays at in_1, replay lasts 8 cycles, results are identical to the unpaused run.
- arst pulsed at cur_idx=2, then start again -> all outputs return to reset values, and the second run completes with pass=1. Separately, start with num_vec=0 -> done=1 and pass=1 on the next cycle.
